// File: rtl/mem_port_arbiter.sv
// Shared memory port arbiter for the fetch and memory stages.
// Data accesses win over fetches; each access has a bounded wait.
module mem_port_arbiter #(
    parameter int Address_Width  = 32,
    parameter int Data_Width     = 32,
    parameter int Timeout_Cycles = 16
) (
    input  logic                     i_CLK,
    input  logic                     i_RST_N,
    input  logic                     i_IF_Req,
    input  logic [Address_Width-1:0] i_IF_Addr,
    output logic                     o_IF_Valid,
    output logic [Data_Width-1:0]    o_IF_RData,
    input  logic                     i_DM_Req,
    input  logic                     i_DM_We,
    input  logic [Address_Width-1:0] i_DM_Addr,
    input  logic [Data_Width-1:0]    i_DM_WData,
    output logic                     o_DM_Valid,
    output logic [Data_Width-1:0]    o_DM_RData,
    input  logic                     i_Flush_IF,
    output logic                     o_Stall_F,
    output logic                     o_Stall_M,
    output logic                     o_Mem_Req,
    output logic                     o_Mem_We,
    output logic [Address_Width-1:0] o_Mem_Addr,
    output logic [Data_Width-1:0]    o_Mem_WData,
    input  logic                     i_Mem_Ready,
    input  logic [Data_Width-1:0]    i_Mem_RData,
    output logic                     o_Timeout_Err
);

    localparam int CW = $clog2(Timeout_Cycles + 1);

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        FETCH,
        DROP
    } state_e;

    state_e                   state_q, state_d;
    logic [CW-1:0]            cnt_q, cnt_d;
    logic [Address_Width-1:0] addr_q, addr_d;
    logic                     we_q, we_d;
    logic [Data_Width-1:0]    wdata_q, wdata_d;
    logic                     if_valid_q, if_valid_d;
    logic [Data_Width-1:0]    if_rdata_q, if_rdata_d;
    logic                     dm_valid_q, dm_valid_d;
    logic [Data_Width-1:0]    dm_rdata_q, dm_rdata_d;
    logic                     err_q, err_d;
    logic                     timeout;

    // Wait limit hit on a cycle where memory still is not ready.
    assign timeout = (cnt_q == CW'(Timeout_Cycles)) && !i_Mem_Ready;

    // Next-state, latch and response logic for the access FSM.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        we_d       = we_q;
        wdata_d    = wdata_q;
        if_valid_d = 1'b0;
        if_rdata_d = if_rdata_q;
        dm_valid_d = 1'b0;
        dm_rdata_d = dm_rdata_q;
        err_d      = err_q;
        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                // A requester with Valid high is completing; skip it.
                if (i_DM_Req && !dm_valid_q) begin
                    state_d = DATA;
                    addr_d  = i_DM_Addr;
                    we_d    = i_DM_We;
                    wdata_d = i_DM_WData;
                end else if (i_IF_Req && !if_valid_q) begin
                    state_d = FETCH;
                    addr_d  = i_IF_Addr;
                    we_d    = 1'b0;
                    wdata_d = '0;
                end
            end
            DATA: begin
                if (i_Mem_Ready) begin
                    state_d    = IDLE;
                    dm_valid_d = 1'b1;
                    dm_rdata_d = we_q ? '0 : i_Mem_RData;
                end else if (timeout) begin
                    state_d    = IDLE;
                    dm_valid_d = 1'b1;
                    dm_rdata_d = '0;
                    err_d      = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            FETCH: begin
                // A flush coinciding with completion just discards the word.
                if (i_Mem_Ready) begin
                    state_d = IDLE;
                    if (!i_Flush_IF) begin
                        if_valid_d = 1'b1;
                        if_rdata_d = i_Mem_RData;
                    end
                end else if (timeout) begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                    if (!i_Flush_IF) begin
                        if_valid_d = 1'b1;
                        if_rdata_d = '0;
                    end
                end else if (i_Flush_IF) begin
                    state_d = DROP;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DROP: begin
                if (i_Mem_Ready) begin
                    state_d = IDLE;
                end else if (timeout) begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge i_CLK) begin
        if (!i_RST_N) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            addr_q     <= '0;
            we_q       <= 1'b0;
            wdata_q    <= '0;
            if_valid_q <= 1'b0;
            if_rdata_q <= '0;
            dm_valid_q <= 1'b0;
            dm_rdata_q <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            we_q       <= we_d;
            wdata_q    <= wdata_d;
            if_valid_q <= if_valid_d;
            if_rdata_q <= if_rdata_d;
            dm_valid_q <= dm_valid_d;
            dm_rdata_q <= dm_rdata_d;
            err_q      <= err_d;
        end
    end

    assign o_Mem_Req     = (state_q != IDLE);
    assign o_Mem_We      = (state_q == DATA) && we_q;
    assign o_Mem_Addr    = addr_q;
    assign o_Mem_WData   = wdata_q;
    assign o_IF_Valid    = if_valid_q;
    assign o_IF_RData    = if_rdata_q;
    assign o_DM_Valid    = dm_valid_q;
    assign o_DM_RData    = dm_rdata_q;
    assign o_Timeout_Err = err_q;

    // Stalls are combinational so a stage releases in its Valid cycle.
    assign o_Stall_F = i_IF_Req && !if_valid_q;
    assign o_Stall_M = i_DM_Req && !dm_valid_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed testbench for mem_port_arbiter.
// Per-cycle vector table plus hand-written multi-cycle sequences.
module tb_mem_port_arbiter;

    logic        clk;
    logic        rst_n;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_valid;
    logic [31:0] if_rdata;
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic        dm_valid;
    logic [31:0] dm_rdata;
    logic        flush;
    logic        stall_f;
    logic        stall_m;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        terr;

    int n_cmp = 0;
    int n_bad = 0;

    mem_port_arbiter #(
        .Address_Width (32),
        .Data_Width    (32),
        .Timeout_Cycles(16)
    ) dut (
        .i_CLK        (clk),
        .i_RST_N      (rst_n),
        .i_IF_Req     (if_req),
        .i_IF_Addr    (if_addr),
        .o_IF_Valid   (if_valid),
        .o_IF_RData   (if_rdata),
        .i_DM_Req     (dm_req),
        .i_DM_We      (dm_we),
        .i_DM_Addr    (dm_addr),
        .i_DM_WData   (dm_wdata),
        .o_DM_Valid   (dm_valid),
        .o_DM_RData   (dm_rdata),
        .i_Flush_IF   (flush),
        .o_Stall_F    (stall_f),
        .o_Stall_M    (stall_m),
        .o_Mem_Req    (mem_req),
        .o_Mem_We     (mem_we),
        .o_Mem_Addr   (mem_addr),
        .o_Mem_WData  (mem_wdata),
        .i_Mem_Ready  (mem_ready),
        .i_Mem_RData  (mem_rdata),
        .o_Timeout_Err(terr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        ifr;
        logic [31:0] ifa;
        logic        dmr;
        logic        dmw;
        logic [31:0] dma;
        logic [31:0] dmd;
        logic        fl;
        logic        rdy;
        logic [31:0] rd;
        logic        e_req;
        logic        e_we;
        logic [31:0] e_addr;
        logic [31:0] e_wd;
        logic        e_ifv;
        logic [31:0] e_ifd;
        logic        e_dmv;
        logic [31:0] e_dmd;
        logic        e_sf;
        logic        e_sm;
        logic        e_err;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(
        input logic ifr, input logic [31:0] ifa,
        input logic dmr, input logic dmw,
        input logic [31:0] dma, input logic [31:0] dmd,
        input logic fl, input logic rdy, input logic [31:0] rd,
        input logic e_req, input logic e_we,
        input logic [31:0] e_addr, input logic [31:0] e_wd,
        input logic e_ifv, input logic [31:0] e_ifd,
        input logic e_dmv, input logic [31:0] e_dmd,
        input logic e_sf, input logic e_sm, input logic e_err);
        vec_t v;
        v.ifr = ifr; v.ifa = ifa; v.dmr = dmr; v.dmw = dmw;
        v.dma = dma; v.dmd = dmd; v.fl = fl; v.rdy = rdy; v.rd = rd;
        v.e_req = e_req; v.e_we = e_we; v.e_addr = e_addr;
        v.e_wd = e_wd; v.e_ifv = e_ifv; v.e_ifd = e_ifd;
        v.e_dmv = e_dmv; v.e_dmd = e_dmd; v.e_sf = e_sf;
        v.e_sm = e_sm; v.e_err = e_err;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t",
                     nm, act, exp, $time);
        end
    endtask

    task automatic idle_in();
        if_req = 0; if_addr = 0; dm_req = 0; dm_we = 0;
        dm_addr = 0; dm_wdata = 0; flush = 0;
        mem_ready = 0; mem_rdata = 0;
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    int nreq;
    bit found;

    initial begin
        rst_n = 0;
        idle_in();
        nxt();
        nxt();
        @(negedge clk);
        chk("rst_mem_req", 32'(mem_req), 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_if_valid", 32'(if_valid), 0);
        chk("rst_dm_valid", 32'(dm_valid), 0);
        chk("rst_err", 32'(terr), 0);
        chk("rst_stalls", {30'd0, stall_f, stall_m}, 0);
        nxt();
        rst_n = 1;

        // Simultaneous requests: data first, then fetch.
        vq.push_back(mk(1, 32'h100, 1, 0, 32'h2000, 0, 0, 0, 0,
                        0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0));
        vq.push_back(mk(1, 32'h100, 1, 0, 32'h2000, 0, 0, 1, 32'hA5A50001,
                        1, 0, 32'h2000, 0, 0, 0, 0, 0, 1, 1, 0));
        vq.push_back(mk(1, 32'h100, 0, 0, 0, 0, 0, 0, 0,
                        0, 0, 0, 0, 0, 0, 1, 32'hA5A50001, 1, 0, 0));
        vq.push_back(mk(1, 32'h100, 0, 0, 0, 0, 0, 1, 32'h11112222,
                        1, 0, 32'h100, 0, 0, 0, 0, 0, 1, 0, 0));
        vq.push_back(mk(1, 32'h100, 0, 0, 0, 0, 0, 0, 0,
                        0, 0, 0, 0, 1, 32'h11112222, 0, 0, 0, 0, 0));
        vq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0,
                        0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        // Write with three wait cycles.
        vq.push_back(mk(0, 0, 1, 1, 32'h40, 32'hDEADBEEF, 0, 0, 0,
                        0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
        for (int i = 0; i < 3; i++)
            vq.push_back(mk(0, 0, 1, 1, 32'h40, 32'hDEADBEEF, 0, 0, 0,
                            1, 1, 32'h40, 32'hDEADBEEF,
                            0, 0, 0, 0, 0, 1, 0));
        vq.push_back(mk(0, 0, 1, 1, 32'h40, 32'hDEADBEEF, 0, 1, 32'h12345678,
                        1, 1, 32'h40, 32'hDEADBEEF, 0, 0, 0, 0, 0, 1, 0));
        vq.push_back(mk(0, 0, 1, 1, 32'h40, 32'hDEADBEEF, 0, 0, 0,
                        0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
        vq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0,
                        0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        // Fetch flushed in its first cycle, then a fresh fetch.
        vq.push_back(mk(1, 32'h8, 0, 0, 0, 0, 0, 0, 0,
                        0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
        vq.push_back(mk(1, 32'h8, 0, 0, 0, 0, 1, 0, 0,
                        1, 0, 32'h8, 0, 0, 0, 0, 0, 1, 0, 0));
        vq.push_back(mk(1, 32'h8, 0, 0, 0, 0, 0, 0, 0,
                        1, 0, 32'h8, 0, 0, 0, 0, 0, 1, 0, 0));
        vq.push_back(mk(1, 32'h8, 0, 0, 0, 0, 0, 1, 32'hCAFE0000,
                        1, 0, 32'h8, 0, 0, 0, 0, 0, 1, 0, 0));
        vq.push_back(mk(1, 32'h200, 0, 0, 0, 0, 0, 0, 0,
                        0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
        vq.push_back(mk(1, 32'h200, 0, 0, 0, 0, 0, 1, 32'h0BADF00D,
                        1, 0, 32'h200, 0, 0, 0, 0, 0, 1, 0, 0));
        vq.push_back(mk(1, 32'h200, 0, 0, 0, 0, 1, 0, 0,
                        0, 0, 0, 0, 1, 32'h0BADF00D, 0, 0, 0, 0, 0));
        vq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0,
                        0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        // Flush during a data read has no effect.
        vq.push_back(mk(0, 0, 1, 0, 32'h44, 0, 1, 0, 0,
                        0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
        vq.push_back(mk(0, 0, 1, 0, 32'h44, 0, 1, 1, 32'h77,
                        1, 0, 32'h44, 0, 0, 0, 0, 0, 0, 1, 0));
        vq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0,
                        0, 0, 0, 0, 0, 0, 1, 32'h77, 0, 0, 0));

        foreach (vq[k]) begin
            if_req = vq[k].ifr; if_addr = vq[k].ifa;
            dm_req = vq[k].dmr; dm_we = vq[k].dmw;
            dm_addr = vq[k].dma; dm_wdata = vq[k].dmd;
            flush = vq[k].fl; mem_ready = vq[k].rdy;
            mem_rdata = vq[k].rd;
            @(negedge clk);
            chk($sformatf("v%0d_req", k), 32'(mem_req), 32'(vq[k].e_req));
            chk($sformatf("v%0d_we", k), 32'(mem_we), 32'(vq[k].e_we));
            if (vq[k].e_req)
                chk($sformatf("v%0d_addr", k), mem_addr, vq[k].e_addr);
            if (vq[k].e_we)
                chk($sformatf("v%0d_wdata", k), mem_wdata, vq[k].e_wd);
            chk($sformatf("v%0d_ifv", k), 32'(if_valid), 32'(vq[k].e_ifv));
            if (vq[k].e_ifv)
                chk($sformatf("v%0d_ifd", k), if_rdata, vq[k].e_ifd);
            chk($sformatf("v%0d_dmv", k), 32'(dm_valid), 32'(vq[k].e_dmv));
            if (vq[k].e_dmv)
                chk($sformatf("v%0d_dmd", k), dm_rdata, vq[k].e_dmd);
            chk($sformatf("v%0d_sf", k), 32'(stall_f), 32'(vq[k].e_sf));
            chk($sformatf("v%0d_sm", k), 32'(stall_m), 32'(vq[k].e_sm));
            chk($sformatf("v%0d_err", k), 32'(terr), 32'(vq[k].e_err));
            nxt();
        end
        idle_in();
        nxt();

        // Ready arrives exactly on the timeout cycle: ready wins.
        if_req = 1; if_addr = 32'h700;
        nxt();
        for (int i = 0; i < 16; i++) nxt();
        mem_ready = 1; mem_rdata = 32'h5555AAAA;
        @(negedge clk);
        chk("coinc_req", 32'(mem_req), 1);
        nxt();
        mem_ready = 0; if_req = 0;
        @(negedge clk);
        chk("coinc_ifv", 32'(if_valid), 1);
        chk("coinc_ifd", if_rdata, 32'h5555AAAA);
        chk("coinc_err", 32'(terr), 0);
        nxt();

        // Data read that never gets ready: abort after the wait limit.
        dm_req = 1; dm_we = 0; dm_addr = 32'h3000;
        nreq = 0;
        found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            if (dm_valid) begin
                found = 1;
                chk("to_req_cycles", 32'(nreq), 17);
                chk("to_dmd", dm_rdata, 0);
                chk("to_req_low", 32'(mem_req), 0);
                chk("to_err", 32'(terr), 1);
            end else if (mem_req) begin
                nreq++;
            end
            nxt();
        end
        if (!found) begin
            n_cmp++;
            n_bad++;
            $display("FAIL to_valid: no o_DM_Valid within 40 cycles");
        end
        dm_req = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("to_err_sticky", 32'(terr), 1);
            chk("to_dmv_once", 32'(dm_valid), 0);
            nxt();
        end

        // Reset in the middle of a fetch wait.
        if_req = 1; if_addr = 32'h500;
        nxt();
        @(negedge clk);
        chk("rf_req", 32'(mem_req), 1);
        nxt();
        rst_n = 0;
        @(negedge clk);
        chk("rf_stall_in_rst", 32'(stall_f), 1);
        nxt();
        rst_n = 1; if_addr = 32'h600;
        @(negedge clk);
        chk("rf_req_low", 32'(mem_req), 0);
        chk("rf_ifv", 32'(if_valid), 0);
        chk("rf_err", 32'(terr), 0);
        nxt();
        mem_ready = 1; mem_rdata = 32'h600D600D;
        @(negedge clk);
        chk("rf_new_req", 32'(mem_req), 1);
        chk("rf_new_addr", mem_addr, 32'h600);
        nxt();
        mem_ready = 0; if_req = 0;
        @(negedge clk);
        chk("rf_new_ifv", 32'(if_valid), 1);
        chk("rf_new_ifd", if_rdata, 32'h600D600D);
        nxt();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
